// File: rtl/uart_rx_majority_sampler_if.sv
// ---------------------------------------------------------------------------
// uart_rx_majority_sampler_if
//
// Purpose : bundles the sampling-side signals of the UART RX majority
//           sampler so that the edge/bit counter, the RX FSM and the sampler
//           share one connection point.
//
// Handshake: Sample_Valid is a one-cycle strobe with no ready/backpressure.
//            When Sample_Valid is 1 on a rising CLK edge, Sampled_Bit (and
//            Noise_Err) carry the freshly voted bit; the consumer must take
//            it in that cycle because there is no way to stall the sampler.
//
// Signals (direction given from the sampler / slave side):
//   Data_samp_en   in   sampling enable from the RX FSM
//   RX_IN          in   serial line, already synchronised
//   Prescale       in   oversampling ratio (even, static while enabled)
//   edge_count     in   current oversample index 0..Prescale-1
//   Sampled_Bit    out  voted bit, registered
//   Sample_Valid   out  one-cycle pulse: Sampled_Bit updated this cycle
//   Noise_Err      out  last vote was not unanimous (0 when feature is off)
//   samp_state_dbg out  sampler FSM state: 0 = IDLE, 1 = COLLECT
//
// Modports:
//   master : the side that drives enable/line/counter and reads the result
//   slave  : the sampler itself
// ---------------------------------------------------------------------------
interface uart_rx_majority_sampler_if #(
  parameter int PRESCALE_W = 6
);
  logic                  Data_samp_en;
  logic                  RX_IN;
  logic [PRESCALE_W-1:0] Prescale;
  logic [PRESCALE_W-1:0] edge_count;
  logic                  Sampled_Bit;
  logic                  Sample_Valid;
  logic                  Noise_Err;
  logic                  samp_state_dbg;

  modport master (
    output Data_samp_en,
    output RX_IN,
    output Prescale,
    output edge_count,
    input  Sampled_Bit,
    input  Sample_Valid,
    input  Noise_Err,
    input  samp_state_dbg
  );

  modport slave (
    input  Data_samp_en,
    input  RX_IN,
    input  Prescale,
    input  edge_count,
    output Sampled_Bit,
    output Sample_Valid,
    output Noise_Err,
    output samp_state_dbg
  );
endinterface

// File: rtl/uart_rx_majority_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_majority_sampler
//
// Purpose : UART RX oversampling bit sampler. Within each bit period it takes
//           NUM_SAMPLES consecutive samples of RX_IN centred on Prescale/2
//           and emits the majority-voted bit with a one-cycle valid strobe.
//           Sits between the RX edge/bit counter and the RX FSM /
//           deserializer / start and parity checkers.
//
// Parameters:
//   PRESCALE_W   width of Prescale and edge_count
//   NUM_SAMPLES  samples per bit; odd, 1..7 (elaboration error otherwise)
//
// Ports:
//   CLK  in  clock, all logic on the rising edge
//   RST  in  asynchronous, active-low reset
//   bus  slave modport of uart_rx_majority_sampler_if:
//        Data_samp_en, RX_IN, Prescale, edge_count  (inputs)
//        Sampled_Bit, Sample_Valid, Noise_Err, samp_state_dbg (outputs)
//
// Configuration macro:
//   UART_RX_SAMP_NOISE_FLAG_EN
//     defined   : Noise_Err is registered with every vote and is 1 when the
//                 samples of that vote were not unanimous; it holds until
//                 the next vote or a clear.
//     undefined : Noise_Err is tied to 0 and no unanimity logic exists.
//
// Operation:
//   Window FIRST = Prescale/2 - HALF .. LAST = Prescale/2 + HALF, with
//   HALF = (NUM_SAMPLES-1)/2. The window is only accepted when edge_count
//   walks through it one step per cycle; any skip or restart aborts the bit
//   silently. The vote is registered on the edge that takes the final
//   sample, so Sample_Valid is seen the cycle after edge_count == LAST.
//   When Prescale < NUM_SAMPLES+1 the window would not fit in the period,
//   so a single sample is taken at Prescale/2 instead.
// ---------------------------------------------------------------------------
module uart_rx_majority_sampler #(
  parameter int PRESCALE_W  = 6,
  parameter int NUM_SAMPLES = 3
) (
  input  logic                        CLK,
  input  logic                        RST,
  uart_rx_majority_sampler_if.slave   bus
);

  // -------------------------------------------------------------------------
  // Parameter checks and derived constants
  // -------------------------------------------------------------------------
  generate
    if ((NUM_SAMPLES < 1) || (NUM_SAMPLES > 7) || ((NUM_SAMPLES % 2) == 0)) begin : g_bad_num_samples
      $error("uart_rx_majority_sampler: NUM_SAMPLES must be odd and in 1..7");
    end
  endgenerate

  localparam int HALF = (NUM_SAMPLES - 1) / 2;
  // Counter width for both the ones count and the sample index.
  localparam int CW   = $clog2(NUM_SAMPLES + 1);
  // One extra bit on window arithmetic keeps FIRST/LAST/expected index from
  // wrapping for any legal Prescale.
  localparam int XW   = PRESCALE_W + 1;

  localparam logic [CW-1:0] HALF_C = CW'(HALF);
  localparam logic [XW-1:0] HALF_X = XW'(HALF);
  localparam logic [XW-1:0] NP1_X  = XW'(NUM_SAMPLES + 1);
`ifdef UART_RX_SAMP_NOISE_FLAG_EN
  localparam logic [CW-1:0] N_C    = CW'(NUM_SAMPLES);
`endif

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  typedef enum logic {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   ones_q,  ones_d;
  logic [CW-1:0]   idx_q,   idx_d;
  logic            bit_q,   bit_d;
  logic            valid_q, valid_d;
`ifdef UART_RX_SAMP_NOISE_FLAG_EN
  logic            noise_q, noise_d;
`endif

  // -------------------------------------------------------------------------
  // Window geometry
  // -------------------------------------------------------------------------
  logic [XW-1:0] p_x;
  logic [XW-1:0] mid_x;
  logic [XW-1:0] first_x;
  logic [XW-1:0] last_x;
  logic [XW-1:0] edge_x;
  logic [XW-1:0] expect_x;
  logic          degenerate;
  logic [CW-1:0] rx_c;
  logic [CW-1:0] ones_sum;

  always_comb begin
    p_x        = {1'b0, bus.Prescale};
    mid_x      = p_x >> 1;
    first_x    = mid_x - HALF_X;
    last_x     = mid_x + HALF_X;
    edge_x     = {1'b0, bus.edge_count};
    // Edge index the next sample of the current window must arrive on.
    expect_x   = first_x + XW'(idx_q);
    degenerate = (p_x < NP1_X);
    rx_c       = CW'(bus.RX_IN);
    ones_sum   = ones_q + rx_c;
  end

  // -------------------------------------------------------------------------
  // Next-state / output logic
  // -------------------------------------------------------------------------
  logic          vote;
  logic [CW-1:0] vote_ones;

  always_comb begin
    state_d   = state_q;
    ones_d    = ones_q;
    idx_d     = idx_q;
    bit_d     = bit_q;
    valid_d   = 1'b0;
`ifdef UART_RX_SAMP_NOISE_FLAG_EN
    noise_d   = noise_q;
`endif
    vote      = 1'b0;
    vote_ones = '0;

    if (!bus.Data_samp_en) begin
      // Synchronous clear; also wins over a vote on the LAST-sample cycle.
      state_d = S_IDLE;
      ones_d  = '0;
      idx_d   = '0;
      bit_d   = 1'b0;
`ifdef UART_RX_SAMP_NOISE_FLAG_EN
      noise_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (degenerate) begin
            // Period too short for the window: single sample at the centre.
            if (edge_x == mid_x) begin
              valid_d = 1'b1;
              bit_d   = bus.RX_IN;
`ifdef UART_RX_SAMP_NOISE_FLAG_EN
              noise_d = 1'b0;
`endif
            end
          end else if (edge_x == first_x) begin
            if (NUM_SAMPLES == 1) begin
              vote      = 1'b1;
              vote_ones = rx_c;
            end else begin
              ones_d  = rx_c;
              idx_d   = CW'(1);
              state_d = S_COLLECT;
            end
          end
        end

        S_COLLECT: begin
          // A Prescale change into the degenerate range mid-window is
          // treated like any other broken window.
          if (!degenerate && (edge_x == expect_x)) begin
            if (edge_x == last_x) begin
              vote      = 1'b1;
              vote_ones = ones_sum;
              state_d   = S_IDLE;
              ones_d    = '0;
              idx_d     = '0;
            end else begin
              ones_d = ones_sum;
              idx_d  = idx_q + CW'(1);
            end
          end else begin
            // edge_count skipped or restarted: drop the partial bit.
            state_d = S_IDLE;
            ones_d  = '0;
            idx_d   = '0;
          end
        end

        default: begin
          state_d = S_IDLE;
          ones_d  = '0;
          idx_d   = '0;
        end
      endcase

      if (vote) begin
        valid_d = 1'b1;
        bit_d   = (vote_ones > HALF_C);
`ifdef UART_RX_SAMP_NOISE_FLAG_EN
        noise_d = (vote_ones != '0) && (vote_ones != N_C);
`endif
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      ones_q  <= '0;
      idx_q   <= '0;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ones_q  <= ones_d;
      idx_q   <= idx_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
    end
  end

`ifdef UART_RX_SAMP_NOISE_FLAG_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      noise_q <= 1'b0;
    end else begin
      noise_q <= noise_d;
    end
  end

  assign bus.Noise_Err = noise_q;
`else
  assign bus.Noise_Err = 1'b0;
`endif

  assign bus.Sampled_Bit    = bit_q;
  assign bus.Sample_Valid   = valid_q;
  assign bus.samp_state_dbg = (state_q == S_COLLECT);

endmodule

// File: tb/tb_uart_rx_majority_sampler.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_majority_sampler
//
// Two samplers (NUM_SAMPLES = 3 and 5) see identical stimulus. A driver
// applies one cycle of inputs at a time and, after the clock edge, asks a
// reference model what each DUT must show; the answer goes into a per-DUT
// expected queue. A monitor on the falling edge pops and compares.
//
// The reference model looks at the recent input history: a vote happens on
// a cycle whose edge_count is LAST when the last NUM_SAMPLES cycles were all
// enabled, out of reset and walked FIRST..LAST one step at a time; the bit is
// the majority of RX over those cycles.
// ---------------------------------------------------------------------------
module tb_uart_rx_majority_sampler;

  localparam int PW = 6;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  uart_rx_majority_sampler_if #(.PRESCALE_W(PW)) u3_if ();
  uart_rx_majority_sampler_if #(.PRESCALE_W(PW)) u5_if ();

  assign u5_if.Data_samp_en = u3_if.Data_samp_en;
  assign u5_if.RX_IN        = u3_if.RX_IN;
  assign u5_if.Prescale     = u3_if.Prescale;
  assign u5_if.edge_count   = u3_if.edge_count;

  uart_rx_majority_sampler #(.PRESCALE_W(PW), .NUM_SAMPLES(3)) dut3 (
    .CLK (clk),
    .RST (rst),
    .bus (u3_if)
  );

  uart_rx_majority_sampler #(.PRESCALE_W(PW), .NUM_SAMPLES(5)) dut5 (
    .CLK (clk),
    .RST (rst),
    .bus (u5_if)
  );

  // -------------------------------------------------------------------------
  // Reference model state
  // -------------------------------------------------------------------------
  typedef struct {
    bit en;
    bit rx;
    int edge_i;
    int p;
  } hent_t;

  hent_t hist[$];

  // Expected entry: [3] valid, [2] bit, [1] noise, [0] FSM must be idle.
  logic [3:0] exp3_q[$];
  logic [3:0] exp5_q[$];

  logic hb3 = 1'b0, hn3 = 1'b0;
  logic hb5 = 1'b0, hn5 = 1'b0;

  int checks = 0;
  int errors = 0;

  function automatic logic [2:0] model_eval(input int n, input logic hb, input logic hn);
    hent_t cur;
    int    half, mid, first, last, ones;
    bit    ok;
    logic  noise;
    cur  = hist[hist.size()-1];
    half = (n - 1) / 2;
    if (!cur.en) return 3'b000;
    mid = cur.p / 2;
    if (cur.p < n + 1) begin
      if (cur.edge_i == mid) return {1'b1, cur.rx, 1'b0};
      return {1'b0, hb, hn};
    end
    first = mid - half;
    last  = mid + half;
    if ((cur.edge_i == last) && (hist.size() >= n)) begin
      ok   = 1'b1;
      ones = 0;
      for (int k = 0; k < n; k++) begin
        hent_t h;
        h = hist[hist.size() - n + k];
        if (!h.en || (h.edge_i != first + k) || (h.p != cur.p)) ok = 1'b0;
        ones += int'(h.rx);
      end
      if (ok) begin
`ifdef UART_RX_SAMP_NOISE_FLAG_EN
        noise = (ones != 0) && (ones != n);
`else
        noise = 1'b0;
`endif
        return {1'b1, (ones > half), noise};
      end
    end
    return {1'b0, hb, hn};
  endfunction

  // -------------------------------------------------------------------------
  // Driver: one cycle of stimulus
  // -------------------------------------------------------------------------
  task automatic drive(input logic en, input logic rx, input int p, input int e, input logic rst_n);
    hent_t      h;
    logic [2:0] r;
    // Reset acts asynchronously, so the outputs registered at the previous
    // edge are already cleared by the time the monitor looks at them.
    if (!rst_n) begin
      if (exp3_q.size() > 0) exp3_q[exp3_q.size()-1] = 4'b0001;
      if (exp5_q.size() > 0) exp5_q[exp5_q.size()-1] = 4'b0001;
    end
    u3_if.Data_samp_en = en;
    u3_if.RX_IN        = rx;
    u3_if.Prescale     = PW'(p);
    u3_if.edge_count   = PW'(e);
    rst                = rst_n;
    @(posedge clk);
    h.en     = en && rst_n;
    h.rx     = rx;
    h.edge_i = e;
    h.p      = p;
    hist.push_back(h);
    if (hist.size() > 8) void'(hist.pop_front());
    if (!rst_n || !en) begin
      hb3 = 1'b0; hn3 = 1'b0; hb5 = 1'b0; hn5 = 1'b0;
      exp3_q.push_back(4'b0001);
      exp5_q.push_back(4'b0001);
    end else begin
      r = model_eval(3, hb3, hn3);
      hb3 = r[1]; hn3 = r[0];
      exp3_q.push_back({r, 1'b0});
      r = model_eval(5, hb5, hn5);
      hb5 = r[1]; hn5 = r[0];
      exp5_q.push_back({r, 1'b0});
    end
    #1;
  endtask

  task automatic gap(input int p);
    drive(1'b0, 1'($urandom_range(0, 1)), p, 0, 1'b1);
  endtask

  // One bit period of edge_count 0..p-1. mode 1: after edge g restart at 0
  // once; mode 2: after edge g jump forward by two.
  task automatic run_period(input int p, input int mode, input int g, input logic [63:0] rx_bits,
                            input int drop_at, input int rst_at);
    int e;
    bit restarted;
    e = 0;
    restarted = 1'b0;
    while (e < p) begin
      drive((e == drop_at) ? 1'b0 : 1'b1, rx_bits[e], p, e, (e == rst_at) ? 1'b0 : 1'b1);
      if ((mode == 1) && (e == g) && !restarted) begin
        restarted = 1'b1;
        e = 0;
      end else if ((mode == 2) && (e == g)) begin
        e += 2;
      end else begin
        e++;
      end
    end
  endtask

  // -------------------------------------------------------------------------
  // Monitor / scoreboard
  // -------------------------------------------------------------------------
  task automatic check(input string name, input logic [3:0] e, input logic [2:0] act, input logic dbg);
    checks++;
    if (act !== e[3:1]) begin
      errors++;
      $display("FAIL %s valid/bit/noise: got %b expected %b at %0t", name, act, e[3:1], $time);
    end
    if (e[0]) begin
      checks++;
      if (dbg !== 1'b0) begin
        errors++;
        $display("FAIL %s state: got %b expected IDLE(0) at %0t", name, dbg, $time);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp3_q.size() > 0)
        check("dut3", exp3_q.pop_front(),
              {u3_if.Sample_Valid, u3_if.Sampled_Bit, u3_if.Noise_Err}, u3_if.samp_state_dbg);
      if (exp5_q.size() > 0)
        check("dut5", exp5_q.pop_front(),
              {u5_if.Sample_Valid, u5_if.Sampled_Bit, u5_if.Noise_Err}, u5_if.samp_state_dbg);
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  int plist[8] = '{2, 4, 6, 8, 10, 12, 16, 20};

  initial begin
    int         cur_p, p, r, mode, g, drop_at, rst_at;
    logic [63:0] rxr;

    // Reset
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8, 0, 1'b0);
    gap(8);

    // Window 3..5 with RX 1,0,1 (two-out-of-three ones)
    run_period(8, 0, 0, 64'h28, -1, -1);
    // N=5 window 6..10 with RX 0,0,1,1,0, then all ones
    gap(16);
    run_period(16, 0, 0, 64'h300, -1, -1);
    run_period(16, 0, 0, {64{1'b1}}, -1, -1);
    // Enable dropped at edge 4, then a full window
    gap(8);
    run_period(8, 0, 0, {64{1'b1}}, 4, -1);
    run_period(8, 0, 0, 64'h38, -1, -1);
    // edge_count 3 then back to 0
    run_period(8, 1, 3, {64{1'b1}}, -1, -1);
    run_period(8, 0, 0, 64'h10, -1, -1);
    // Degenerate period: single sample at edge 1
    gap(2);
    run_period(2, 0, 0, 64'h2, -1, -1);
    run_period(2, 0, 0, 64'h0, -1, -1);
    // Reset at edge 4 of a window
    gap(8);
    run_period(8, 0, 0, {64{1'b1}}, -1, 4);
    run_period(8, 0, 0, {64{1'b1}}, -1, -1);

    // Random periods
    cur_p = 8;
    for (int it = 0; it < 60; it++) begin
      p = plist[$urandom_range(0, 7)];
      if ((p != cur_p) || ($urandom_range(0, 3) == 0)) gap(p);
      cur_p   = p;
      r       = $urandom_range(0, 9);
      mode    = (r == 7) ? 1 : ((r == 8) ? 2 : 0);
      g       = $urandom_range(0, p - 1);
      drop_at = (r == 9) ? $urandom_range(0, p - 1) : -1;
      rst_at  = ($urandom_range(0, 19) == 0) ? $urandom_range(0, p - 1) : -1;
      rxr     = {$urandom, $urandom};
      run_period(p, mode, g, rxr, drop_at, rst_at);
    end

    gap(8);
    gap(8);
    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
